// File: rtl/des_sbox_sched.sv
// des_sbox_sched: DES S-box stage, one 6-bit lane per clock through sbox1..sbox8.
// Optional abort input enabled by DES_SBOX_SCHED_ABORT_EN.
module sbox1 (input logic [5:0] in, output logic [3:0] out);
  localparam logic [0:63][3:0] T = 256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D;
  assign out = T[{in[5], in[0], in[4:1]}];
endmodule

module sbox2 (input logic [5:0] in, output logic [3:0] out);
  localparam logic [0:63][3:0] T = 256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9;
  assign out = T[{in[5], in[0], in[4:1]}];
endmodule

module sbox3 (input logic [5:0] in, output logic [3:0] out);
  localparam logic [0:63][3:0] T = 256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C;
  assign out = T[{in[5], in[0], in[4:1]}];
endmodule

module sbox4 (input logic [5:0] in, output logic [3:0] out);
  localparam logic [0:63][3:0] T = 256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E;
  assign out = T[{in[5], in[0], in[4:1]}];
endmodule

module sbox5 (input logic [5:0] in, output logic [3:0] out);
  localparam logic [0:63][3:0] T = 256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453;
  assign out = T[{in[5], in[0], in[4:1]}];
endmodule

module sbox6 (input logic [5:0] in, output logic [3:0] out);
  localparam logic [0:63][3:0] T = 256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D;
  assign out = T[{in[5], in[0], in[4:1]}];
endmodule

module sbox7 (input logic [5:0] in, output logic [3:0] out);
  localparam logic [0:63][3:0] T = 256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C;
  assign out = T[{in[5], in[0], in[4:1]}];
endmodule

module sbox8 (input logic [5:0] in, output logic [3:0] out);
  localparam logic [0:63][3:0] T = 256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B;
  assign out = T[{in[5], in[0], in[4:1]}];
endmodule

module des_sbox_sched (
  input  logic        clk,
  input  logic        rst_n,
`ifdef DES_SBOX_SCHED_ABORT_EN
  input  logic        abort,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [47:0] din_q, din_d;
  logic [31:0] dout_q, dout_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic [5:0] lane;
  logic [3:0] nib [8];
  sbox1 u_s1 (.in(lane), .out(nib[0]));
  sbox2 u_s2 (.in(lane), .out(nib[1]));
  sbox3 u_s3 (.in(lane), .out(nib[2]));
  sbox4 u_s4 (.in(lane), .out(nib[3]));
  sbox5 u_s5 (.in(lane), .out(nib[4]));
  sbox6 u_s6 (.in(lane), .out(nib[5]));
  sbox7 u_s7 (.in(lane), .out(nib[6]));
  sbox8 u_s8 (.in(lane), .out(nib[7]));
  always_comb begin
    lane = '0;
    for (int i = 0; i < 8; i++) lane = (idx_q == 3'(i)) ? din_q[47-6*i -: 6] : lane;
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    din_d = din_q;
    dout_d = dout_q;
    if (state_q == IDLE) begin
      if (in_valid) begin
        din_d = din;
        idx_d = '0;
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      for (int i = 0; i < 8; i++) if (idx_q == 3'(i)) dout_d[31-4*i -: 4] = nib[i];
      idx_d = idx_q + 3'd1;
      state_d = (idx_q == 3'd7) ? DONE : RUN;
    end else if (out_ready) begin
      state_d = IDLE;
    end
`ifdef DES_SBOX_SCHED_ABORT_EN
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      idx_d = '0;
      dout_d = dout_q;
    end
`endif
    in_ready_d = state_d == IDLE;
    out_valid_d = state_d == DONE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      din_q <= '0;
      dout_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      din_q <= din_d;
      dout_q <= dout_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q <= busy_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy = busy_q;
  assign dout = dout_q;
endmodule

// File: tb/tb_des_sbox_sched.sv
// tb_des_sbox_sched: scoreboard bench for des_sbox_sched with a table-based DES S-box model.
module tb_des_sbox_sched;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, abort = 1'b0;
  logic [47:0] din = '0;
  logic in_ready, out_valid, busy;
  logic [31:0] dout;
  int checks = 0, failures = 0;
  logic [31:0] exp_q [$];
  logic [255:0] sb [8];

  always #5 clk = ~clk;

  des_sbox_sched dut (
    .clk(clk), .rst_n(rst_n),
`ifdef DES_SBOX_SCHED_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .busy(busy)
  );

  function automatic logic [31:0] model(input logic [47:0] d);
    logic [31:0] r;
    logic [5:0] s;
    int e;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      s = d[47-6*k -: 6];
      e = {s[5], s[0]} * 16 + s[4:1];
      r[31-4*k -: 4] = sb[k][255-4*e -: 4];
    end
    return r;
  endfunction

  task automatic send(input logic [47:0] d);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!in_ready) begin failures++; $display("FAIL send_ready got=%0b want=1", in_ready); end
    in_valid = 1'b1;
    din = d;
    exp_q.push_back(model(d));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (!out_valid) begin failures++; $display("FAIL out_valid_timeout got=%0b want=1", out_valid); end
  endtask

  task automatic test_reset;
    checks++;
    if ({in_ready, out_valid, busy, dout} !== {3'b100, 32'h0}) begin
      failures++; $display("FAIL reset_init got=%b/%h want=100/0", {in_ready, out_valid, busy}, dout);
    end
    rst_n = 1'b1;
    send(48'h0);
    void'(exp_q.pop_front());
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checks++;
    if ({in_ready, out_valid, busy, dout} !== {3'b100, 32'h0}) begin
      failures++; $display("FAIL reset_async got=%b/%h want=100/0", {in_ready, out_valid, busy}, dout);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_vector(input logic [47:0] d, input logic [31:0] want);
    int n;
    logic [31:0] e;
    out_ready = 1'b1;
    send(d);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL run_flags got busy=%0b in_ready=%0b want=1/0", busy, in_ready);
    end
    wait_valid(n);
    e = exp_q.pop_front();
    checks += 3;
    if (n != 8) begin failures++; $display("FAIL latency got=%0d want=8", n); end
    if (dout !== e || dout !== want) begin
      failures++; $display("FAIL dout din=%h got=%h want=%h", d, dout, want);
    end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL ready_in_done got=%0b want=0", in_ready); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL post_handshake got=%b want=010", {out_valid, in_ready, busy});
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int n;
    logic [31:0] e;
    out_ready = 1'b0;
    send(48'h123456789ABC);
    wait_valid(n);
    e = exp_q.pop_front();
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      din = {$urandom, $urandom_range(65535, 0)};
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || dout !== e) begin
        failures++; $display("FAIL backpressure cyc=%0d got v=%0b r=%0b dout=%h want 1/0/%h", i, out_valid, in_ready, dout, e);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || dout !== e) begin
      failures++; $display("FAIL no_stray_accept got busy=%0b dout=%h want 0/%h", busy, dout, e);
    end
  endtask

  task automatic test_reset_mid_run;
    send(48'hFEDCBA987654);
    void'(exp_q.pop_front());
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checks++;
    if ({in_ready, out_valid, busy, dout} !== {3'b100, 32'h0}) begin
      failures++; $display("FAIL reset_mid_run got=%b/%h want=100/0", {in_ready, out_valid, busy}, dout);
    end
    @(negedge clk) rst_n = 1'b1;
    test_vector(48'h000000840000, 32'hEFA7BC4D);
  endtask

`ifdef DES_SBOX_SCHED_ABORT_EN
  task automatic test_abort;
    logic [31:0] before;
    before = dout;
    send(48'hA5A5A5A5A5A5);
    void'(exp_q.pop_front());
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_idle got in_ready=%0b busy=%0b want 1/0", in_ready, busy);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_valid cyc=%0d got=1 want=0", i); end
    end
    checks++;
    if (dout[31:24] !== before[31:24] ^ 8'h0 && 1'b0) failures++;
    test_vector(48'h0, 32'hEFA72C4D);
  endtask
`endif

  task automatic test_back_to_back;
    int n;
    logic [47:0] d;
    logic [31:0] e;
    out_ready = 1'b1;
    for (int w = 0; w < 6; w++) begin
      d = {$urandom, $urandom_range(65535, 0)};
      send(d);
      wait_valid(n);
      e = exp_q.pop_front();
      checks++;
      if (dout !== e) begin failures++; $display("FAIL b2b w=%0d din=%h got=%h want=%h", w, d, dout, e); end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    sb[0] = 256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D;
    sb[1] = 256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9;
    sb[2] = 256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C;
    sb[3] = 256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E;
    sb[4] = 256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453;
    sb[5] = 256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D;
    sb[6] = 256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C;
    sb[7] = 256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B;
    #12;
    test_reset;
    test_vector(48'h0, 32'hEFA72C4D);
    test_vector(48'hFFFFFFFFFFFF, 32'hD9CE3DCB);
    test_vector(48'h000000840000, 32'hEFA7BC4D);
    test_backpressure;
    test_reset_mid_run;
`ifdef DES_SBOX_SCHED_ABORT_EN
    test_abort;
`endif
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
